// File: rtl/otter_hazard_pkg.sv
// Shared types and helpers for the OTTER pipeline hazard controller.
package otter_hazard_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Forward select for one E-stage source operand. The M-stage result is
    // younger than the W-stage result, so it wins when both match.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count events, clear has priority, never wrap past the maximum.
    always_ff @(posedge CLK) begin
        if (i_clr) begin
            r_count <= {W{1'b0}};
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage OTTER pipeline: stall/flush
// generation, E-stage forwarding, data-memory wait handling with timeout,
// post-reset fill bubbles and saturating stall/redirect counters.
module otter_hazard_ctrl
    import otter_hazard_pkg::*;
#(
    parameter int FILL_CYCLES = 2,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_E,
    input  logic [4:0]       rd_M,
    input  logic [4:0]       rd_W,
    input  logic             regWrite_M,
    input  logic             regWrite_W,
    input  logic             memRead2_E,
    input  logic             pc_src_E,
    input  logic             dmem_req_M,
    input  logic             dmem_ready_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 2);
    localparam logic [FILL_W-1:0] FILL_INIT = FILL_W'(FILL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FILL_W-1:0]   r_fill_cnt;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic                w_load_use;
    logic                w_stall_f;
    logic                w_stall_d;
    logic                w_stall_e;
    logic                w_stall_m;
    logic                w_flush_d;
    logic                w_flush_e;
    logic                w_timeout;
    logic                w_redirect;
    logic                w_any_stall;
    logic [1:0]          w_fwd_a;
    logic [1:0]          w_fwd_b;

    assign w_wait_inc = r_wait_cnt + WAIT_W'(1);
    assign w_load_use = memRead2_E && (rd_E != 5'd0) &&
                        ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));

    // State, fill-count and wait-count registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= FILL;
            r_fill_cnt <= FILL_INIT;
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Next-state and Mealy stall/flush decode; priority: mem wait, redirect, load-use.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_stall_e   = 1'b0;
        w_stall_m   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_timeout   = 1'b0;
        w_redirect  = 1'b0;
        if (RST) begin
            w_flush_d   = 1'b1;
            w_flush_e   = 1'b1;
            w_state_nxt = FILL;
            w_fill_nxt  = FILL_INIT;
            w_wait_nxt  = {WAIT_W{1'b0}};
        end else begin
            case (r_state)
                FILL: begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                    if (r_fill_cnt == {FILL_W{1'b0}}) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_fill_nxt = r_fill_cnt - FILL_W'(1);
                    end
                end
                RUN, MEM_WAIT: begin
                    if ((r_state == RUN) && dmem_req_M && !dmem_ready_M) begin
                        // First frozen cycle; a held redirect waits for release.
                        w_stall_f  = 1'b1;
                        w_stall_d  = 1'b1;
                        w_stall_e  = 1'b1;
                        w_stall_m  = 1'b1;
                        w_wait_nxt = WAIT_W'(1);
                        if (TIMEOUT == 1) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_state_nxt = MEM_WAIT;
                        end
                    end else if ((r_state == MEM_WAIT) && !dmem_ready_M) begin
                        w_stall_f  = 1'b1;
                        w_stall_d  = 1'b1;
                        w_stall_e  = 1'b1;
                        w_stall_m  = 1'b1;
                        w_wait_nxt = w_wait_inc;
                        if ((TIMEOUT != 0) && (w_wait_inc == TIMEOUT_W)) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_state_nxt = MEM_WAIT;
                        end
                    end else begin
                        // Normal issue, also the release cycle of a memory wait.
                        w_state_nxt = RUN;
                        if (pc_src_E) begin
                            // The D instruction is wrong-path, so no load-use stall.
                            w_flush_d  = 1'b1;
                            w_flush_e  = 1'b1;
                            w_redirect = 1'b1;
                        end else if (w_load_use) begin
                            w_stall_f = 1'b1;
                            w_stall_d = 1'b1;
                            w_flush_e = 1'b1;
                        end else begin
                            w_flush_d = 1'b0;
                        end
                    end
                end
                ERR: begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_stall_e = 1'b1;
                    w_stall_m = 1'b1;
                    w_timeout = 1'b1;
                end
                default: begin
                    w_state_nxt = FILL;
                    w_fill_nxt  = FILL_INIT;
                    w_wait_nxt  = {WAIT_W{1'b0}};
                    w_flush_d   = 1'b1;
                    w_flush_e   = 1'b1;
                end
            endcase
        end
    end

    // Operand forwarding select, held at no-forward during reset.
    always_comb begin
        w_fwd_a = FWD_NONE;
        w_fwd_b = FWD_NONE;
        if (RST) begin
            w_fwd_a = FWD_NONE;
            w_fwd_b = FWD_NONE;
        end else begin
            w_fwd_a = fwd_select(rs1_addr_E, rd_M, regWrite_M, rd_W, regWrite_W);
            w_fwd_b = fwd_select(rs2_addr_E, rd_M, regWrite_M, rd_W, regWrite_W);
        end
    end

    assign w_any_stall = w_stall_f | w_stall_d | w_stall_e | w_stall_m;

    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK     (CLK),
        .i_clr   (RST),
        .i_inc   (w_any_stall),
        .o_count (stall_cnt)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK     (CLK),
        .i_clr   (RST),
        .i_inc   (w_redirect),
        .o_count (flush_cnt)
    );

    assign stall_F     = w_stall_f;
    assign stall_D     = w_stall_d;
    assign stall_E     = w_stall_e;
    assign stall_M     = w_stall_m;
    assign flush_D     = w_flush_d;
    assign flush_E     = w_flush_e;
    assign fwdA_E      = w_fwd_a;
    assign fwdB_E      = w_fwd_b;
    assign mem_timeout = w_timeout;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed self-checking bench for otter_hazard_ctrl. A second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_otter_hazard_ctrl;

    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_FLUSH  = 6'b000011;
    localparam logic [5:0] C_FREEZE = 6'b111100;
    localparam logic [5:0] C_LDUSE  = 6'b110001;

    logic        CLK;
    logic        RST;
    logic [4:0]  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
    logic [4:0]  rd_E, rd_M, rd_W;
    logic        regWrite_M, regWrite_W, memRead2_E, pc_src_E;
    logic        dmem_req_M, dmem_ready_M;

    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
    logic [1:0]  fwdA_E, fwdB_E;
    logic        mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_stall_F, s_stall_D, s_stall_E, s_stall_M, s_flush_D, s_flush_E;
    logic [1:0]  s_fwdA_E, s_fwdB_E;
    logic        s_mem_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks;
    int n_errors;

    otter_hazard_ctrl #(.FILL_CYCLES(2), .TIMEOUT(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .memRead2_E(memRead2_E), .pc_src_E(pc_src_E),
        .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    otter_hazard_ctrl #(.FILL_CYCLES(2), .TIMEOUT(4), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .memRead2_E(memRead2_E), .pc_src_E(pc_src_E),
        .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
        .stall_F(s_stall_F), .stall_D(s_stall_D), .stall_E(s_stall_E), .stall_M(s_stall_M),
        .flush_D(s_flush_D), .flush_E(s_flush_E),
        .fwdA_E(s_fwdA_E), .fwdB_E(s_fwdB_E),
        .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E} of both instances.
    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check_val(tag, {26'd0, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}, {26'd0, exp});
        check_val({tag, "_sat"}, {26'd0, s_stall_F, s_stall_D, s_stall_E, s_stall_M,
                  s_flush_D, s_flush_E}, {26'd0, exp});
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
        check_val({tag, "_A"}, {30'd0, fwdA_E}, {30'd0, exp_a});
        check_val({tag, "_B"}, {30'd0, fwdB_E}, {30'd0, exp_b});
        check_val({tag, "_sat"}, {28'd0, s_fwdA_E, s_fwdB_E}, {28'd0, exp_a, exp_b});
    endtask

    task automatic check_to(input string tag, input logic exp);
        check_val(tag, {31'd0, mem_timeout}, {31'd0, exp});
        check_val({tag, "_sat"}, {31'd0, s_mem_timeout}, {31'd0, exp});
    endtask

    task automatic set_idle();
        rs1_addr_D = 5'd0; rs2_addr_D = 5'd0; rs1_addr_E = 5'd0; rs2_addr_E = 5'd0;
        rd_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0;
        regWrite_M = 1'b0; regWrite_W = 1'b0; memRead2_E = 1'b0; pc_src_E = 1'b0;
        dmem_req_M = 1'b0; dmem_ready_M = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        set_idle();
        RST = 1'b1;

        // Reset: flushes high, stalls low, forwarding suppressed, counters cleared.
        tick(); rd_M = 5'd7; regWrite_M = 1'b1; rs1_addr_E = 5'd7; smp();
        check_ctrl("rst_ctrl", C_FLUSH);
        check_fwd("rst_fwd", 2'b00, 2'b00);
        check_val("rst_stall_cnt", stall_cnt, 32'd0);
        check_val("rst_flush_cnt", flush_cnt, 32'd0);
        check_to("rst_timeout", 1'b0);

        // Two fill bubbles then RUN.
        tick(); RST = 1'b0; set_idle(); smp(); check_ctrl("fill1", C_FLUSH);
        tick(); smp(); check_ctrl("fill2", C_FLUSH);
        tick(); smp(); check_ctrl("run0", C_IDLE);

        // Forwarding patterns.
        tick(); regWrite_M = 1'b1; regWrite_W = 1'b1; rd_M = 5'd7; rd_W = 5'd7;
        rs1_addr_E = 5'd7; rs2_addr_E = 5'd7; smp();
        check_fwd("fwd_both", 2'b10, 2'b10);
        tick(); regWrite_M = 1'b0; smp();
        check_fwd("fwd_wb", 2'b01, 2'b01);
        tick(); regWrite_M = 1'b1; rd_M = 5'd0; rd_W = 5'd0; rs1_addr_E = 5'd0;
        rs2_addr_E = 5'd9; smp();
        check_fwd("fwd_x0", 2'b00, 2'b00);
        tick(); rd_M = 5'd9; rd_W = 5'd3; rs1_addr_E = 5'd3; rs2_addr_E = 5'd9; smp();
        check_fwd("fwd_mix", 2'b01, 2'b10);
        check_ctrl("fwd_ctrl", C_IDLE);

        // Load-use on rs2: one bubble, then clear.
        tick(); set_idle(); memRead2_E = 1'b1; rd_E = 5'd5; rs1_addr_D = 5'd1;
        rs2_addr_D = 5'd5; smp();
        check_ctrl("ldu", C_LDUSE);
        tick(); set_idle(); smp();
        check_ctrl("ldu_after", C_IDLE);
        check_val("ldu_stall_cnt", stall_cnt, 32'd1);
        tick(); memRead2_E = 1'b1; rd_E = 5'd0; rs1_addr_D = 5'd0; smp();
        check_ctrl("ldu_x0", C_IDLE);

        // Redirect beats load-use.
        tick(); set_idle(); memRead2_E = 1'b1; rd_E = 5'd5; rs1_addr_D = 5'd5;
        pc_src_E = 1'b1; smp();
        check_ctrl("redir_ldu", C_FLUSH);
        tick(); set_idle(); smp();
        check_val("redir_flush_cnt", flush_cnt, 32'd1);
        check_val("redir_stall_cnt", stall_cnt, 32'd1);

        // Memory wait of three cycles with a held redirect.
        tick(); dmem_req_M = 1'b1; pc_src_E = 1'b1; smp(); check_ctrl("wait1", C_FREEZE);
        tick(); smp(); check_ctrl("wait2", C_FREEZE);
        tick(); smp(); check_ctrl("wait3", C_FREEZE);
        tick(); dmem_ready_M = 1'b1; smp(); check_ctrl("wait_release", C_FLUSH);
        tick(); set_idle(); smp();
        check_ctrl("wait_after", C_IDLE);
        check_val("wait_flush_cnt", flush_cnt, 32'd2);
        check_val("wait_stall_cnt", stall_cnt, 32'd4);
        check_val("sat_stall_cnt", {30'd0, s_stall_cnt}, 32'd3);
        check_val("sat_flush_cnt2", {30'd0, s_flush_cnt}, 32'd2);

        // Two more redirects: wide counter reaches 4, narrow one holds at 3.
        tick(); pc_src_E = 1'b1; smp();
        tick(); smp();
        tick(); set_idle(); smp();
        check_val("flush_cnt4", flush_cnt, 32'd4);
        check_val("sat_flush_cnt", {30'd0, s_flush_cnt}, 32'd3);

        // Timeout: four wait cycles then ERR until reset.
        tick(); dmem_req_M = 1'b1; smp();
        check_ctrl("to_w1", C_FREEZE);
        for (int i = 0; i < 3; i++) begin
            tick(); smp();
            check_ctrl("to_wn", C_FREEZE);
            check_to("to_pending", 1'b0);
        end
        tick(); smp();
        check_ctrl("err", C_FREEZE);
        check_to("err_flag", 1'b1);
        tick(); dmem_ready_M = 1'b1; pc_src_E = 1'b1; smp();
        check_ctrl("err_hold", C_FREEZE);
        check_to("err_hold_flag", 1'b1);
        tick(); RST = 1'b1; smp();
        check_ctrl("err_rst", C_FLUSH);
        check_to("err_rst_flag", 1'b0);
        check_val("err_stall_cnt", stall_cnt, 32'd10);
        check_val("err_flush_cnt", flush_cnt, 32'd4);

        // Reset in the middle of FILL restarts the whole fill sequence.
        tick(); RST = 1'b0; set_idle(); smp();
        check_ctrl("refill0", C_FLUSH);
        check_val("clr_stall_cnt", stall_cnt, 32'd0);
        check_val("clr_flush_cnt", flush_cnt, 32'd0);
        tick(); RST = 1'b1; smp(); check_ctrl("mid_fill_rst", C_FLUSH);
        tick(); RST = 1'b0; smp(); check_ctrl("refill1", C_FLUSH);
        tick(); smp(); check_ctrl("refill2", C_FLUSH);
        tick(); smp(); check_ctrl("rerun", C_IDLE);

        // Reset in the middle of a memory wait also restarts FILL.
        tick(); dmem_req_M = 1'b1; smp(); check_ctrl("mw_freeze", C_FREEZE);
        tick(); smp(); check_ctrl("mw_freeze2", C_FREEZE);
        tick(); RST = 1'b1; smp(); check_ctrl("mw_rst", C_FLUSH);
        tick(); RST = 1'b0; set_idle(); smp(); check_ctrl("mw_fill1", C_FLUSH);
        tick(); smp(); check_ctrl("mw_fill2", C_FLUSH);
        tick(); smp(); check_ctrl("mw_run", C_IDLE);
        check_to("mw_flag", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
